// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Brief    : Start/stop framed, strobe-qualified serial receiver with a
//            single-entry valid/ready holding buffer and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_i,
    input  logic             ser_en_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             frame_err_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             r_wait_high;
    logic             w_start;
    logic             w_shift;
    logic             w_load;
    logic             w_overrun;
    logic             w_ferr;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shift_next = {ser_i, r_shift[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], ser_i};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (ser_en_i && !ser_i && !r_wait_high) w_state_next = S_DATA;
            S_DATA: if (ser_en_i && (r_cnt == c_cnt_last)) w_state_next = S_STOP;
            S_STOP: if (ser_en_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A good stop bit loads only if the buffer is empty or being drained this edge.
    always_comb begin
        busy_o    = (r_state != S_IDLE);
        w_start   = (r_state == S_IDLE) && ser_en_i && !ser_i && !r_wait_high;
        w_shift   = (r_state == S_DATA) && ser_en_i;
        w_load    = (r_state == S_STOP) && ser_en_i && ser_i && (!valid_o || ready_i);
        w_overrun = (r_state == S_STOP) && ser_en_i && ser_i && valid_o && !ready_i;
        w_ferr    = (r_state == S_STOP) && ser_en_i && !ser_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_wait_high <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_shift) begin
                r_shift <= w_shift_next;
            end
            // After a bad stop bit the line must be seen high before a new start.
            if (w_ferr) begin
                r_wait_high <= 1'b1;
            end else if ((r_state == S_IDLE) && ser_en_i && ser_i) begin
                r_wait_high <= 1'b0;
            end
            if (w_load) begin
                data_o <= r_shift;
            end
            valid_o     <= w_load || (valid_o && !ready_i);
            overrun_o   <= w_overrun;
            frame_err_o <= w_ferr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Brief    : Directed, self-checking bench for serial_frame_rx (both bit orders).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    localparam int WIDTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             ser_i = 1'b1;
    logic             ser_en_i = 1'b0;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] data_l, data_m;
    logic             valid_l, valid_m, busy_l, busy_m;
    logic             ovr_l, ovr_m, ferr_l, ferr_m;

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b1;

    always #5 clk_i = ~clk_i;

    serial_frame_rx #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_l (
        .clk_i(clk_i), .rst_i(rst_i), .ser_i(ser_i), .ser_en_i(ser_en_i),
        .data_o(data_l), .valid_o(valid_l), .ready_i(ready_i), .busy_o(busy_l),
        .overrun_o(ovr_l), .frame_err_o(ferr_l)
    );

    serial_frame_rx #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_m (
        .clk_i(clk_i), .rst_i(rst_i), .ser_i(ser_i), .ser_en_i(ser_en_i),
        .data_o(data_m), .valid_o(valid_m), .ready_i(ready_i), .busy_o(busy_m),
        .overrun_o(ovr_m), .frame_err_o(ferr_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collects strobed samples and judges a frame once all
    // WIDTH+2 bits are in; words are assembled arithmetically for both orders.
    logic             m_q[$];
    bit               m_wait;
    logic [WIDTH-1:0] m_data_l, m_data_m;
    bit               m_valid, m_ovr, m_ferr;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_q.delete();
            m_wait = 0; m_data_l = '0; m_data_m = '0;
            m_valid = 0; m_ovr = 0; m_ferr = 0;
        end else begin
            bit load, drain;
            load  = 0;
            drain = m_valid && ready_i;
            m_ovr = 0;
            m_ferr = 0;
            if (ser_en_i) begin
                if (m_q.size() == 0) begin
                    if (ser_i) m_wait = 0;
                    else if (!m_wait) m_q.push_back(1'b0);
                end else begin
                    m_q.push_back(ser_i);
                    if (m_q.size() == WIDTH + 2) begin
                        if (!ser_i) begin
                            m_ferr = 1; m_wait = 1;
                        end else if (!m_valid || ready_i) begin
                            load = 1;
                            for (int i = 0; i < WIDTH; i++) begin
                                m_data_l[i]           = m_q[i+1];
                                m_data_m[WIDTH-1-i]   = m_q[i+1];
                            end
                        end else begin
                            m_ovr = 1;
                        end
                        m_q.delete();
                    end
                end
            end
            if (load) m_valid = 1;
            else if (drain) m_valid = 0;
        end
    end

    always @(negedge clk_i) begin
        if (run_cmp) begin
            check("cmp data_l",  32'(data_l),  32'(m_data_l));
            check("cmp data_m",  32'(data_m),  32'(m_data_m));
            check("cmp valid_l", 32'(valid_l), 32'(m_valid));
            check("cmp valid_m", 32'(valid_m), 32'(m_valid));
            check("cmp busy_l",  32'(busy_l),  32'(m_q.size() != 0));
            check("cmp busy_m",  32'(busy_m),  32'(m_q.size() != 0));
            check("cmp ovr",     32'({ovr_l, ovr_m}),   32'({m_ovr, m_ovr}));
            check("cmp ferr",    32'({ferr_l, ferr_m}), 32'({m_ferr, m_ferr}));
        end
    end

    // Drive one cycle of inputs, return 1ns after the following falling edge.
    task automatic bitcyc(input logic s, input logic en);
        ser_i = s;
        ser_en_i = en;
        @(negedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop,
                              input logic rdy_data, input logic rdy_stop);
        ready_i = rdy_data;
        bitcyc(1'b0, 1'b1);
        for (int i = 0; i < WIDTH; i++) bitcyc(w[i], 1'b1);
        ready_i = rdy_stop;
        bitcyc(stop, 1'b1);
        ready_i = 1'b0;
    endtask

    task automatic lit(input string name, input logic [WIDTH-1:0] dl, input logic [WIDTH-1:0] dm,
                       input logic v, input logic o, input logic f);
        check({name, " data_l"}, 32'(data_l), 32'(dl));
        check({name, " data_m"}, 32'(data_m), 32'(dm));
        check({name, " valid"},  32'({valid_l, valid_m}), 32'({v, v}));
        check({name, " ovr"},    32'({ovr_l, ovr_m}),     32'({o, o}));
        check({name, " ferr"},   32'({ferr_l, ferr_m}),   32'({f, f}));
    endtask

    initial begin
        @(negedge clk_i); #1;
        lit("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("reset busy", 32'({busy_l, busy_m}), 32'd0);
        bitcyc(1'b1, 1'b0);
        rst_i = 1'b1;
        bitcyc(1'b1, 1'b0);

        // Basic frame, both bit orders: 0,1,0,1,1,1
        send_frame(4'hD, 1'b1, 1'b0, 1'b0);
        lit("basic", 4'hD, 4'hB, 1'b1, 1'b0, 1'b0);
        check("basic busy", 32'({busy_l, busy_m}), 32'd0);
        ready_i = 1'b1;
        bitcyc(1'b1, 1'b0);
        ready_i = 1'b0;
        lit("basic drain", 4'hD, 4'hB, 1'b0, 1'b0, 1'b0);

        // Overrun with a full buffer, then a load coinciding with a drain
        send_frame(4'hD, 1'b1, 1'b0, 1'b0);
        send_frame(4'h3, 1'b1, 1'b0, 1'b0);
        lit("overrun", 4'hD, 4'hB, 1'b1, 1'b1, 1'b0);
        bitcyc(1'b1, 1'b0);
        lit("overrun end", 4'hD, 4'hB, 1'b1, 1'b0, 1'b0);
        send_frame(4'h3, 1'b1, 1'b0, 1'b1);
        lit("load+drain", 4'h3, 4'hC, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b1;
        bitcyc(1'b1, 1'b0);
        ready_i = 1'b0;

        // Framing error; a low line right after must not start a frame
        send_frame(4'hA, 1'b0, 1'b0, 1'b0);
        lit("ferr", 4'h3, 4'hC, 1'b0, 1'b0, 1'b1);
        check("ferr busy", 32'({busy_l, busy_m}), 32'd0);
        bitcyc(1'b0, 1'b1);
        lit("ferr end", 4'h3, 4'hC, 1'b0, 1'b0, 1'b0);
        check("ferr no restart", 32'({busy_l, busy_m}), 32'd0);
        bitcyc(1'b1, 1'b1);
        send_frame(4'h5, 1'b1, 1'b0, 1'b0);
        lit("after ferr", 4'h5, 4'hA, 1'b1, 1'b0, 1'b0);
        ready_i = 1'b1;
        bitcyc(1'b1, 1'b0);
        ready_i = 1'b0;

        // Sparse strobes: line toggles on unstrobed cycles
        begin
            logic [5:0] fr;
            fr = {1'b1, 4'hD, 1'b0};
            for (int i = 0; i < 6; i++) begin
                bitcyc(fr[i], 1'b1);
                if (i < 5) check("sparse busy", 32'({busy_l, busy_m}), 32'b11);
                bitcyc(~fr[i], 1'b0);
                if (i < 5) check("sparse busy", 32'({busy_l, busy_m}), 32'b11);
                bitcyc(fr[i], 1'b0);
            end
        end
        lit("sparse", 4'hD, 4'hB, 1'b1, 1'b0, 1'b0);

        // Mid-frame reset while a word is still held
        bitcyc(1'b0, 1'b1);
        bitcyc(1'b1, 1'b1);
        bitcyc(1'b1, 1'b1);
        rst_i = 1'b0;
        #1;
        lit("async rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("async rst busy", 32'({busy_l, busy_m}), 32'd0);
        bitcyc(1'b1, 1'b0);
        rst_i = 1'b1;
        bitcyc(1'b1, 1'b0);
        send_frame(4'h9, 1'b1, 1'b0, 1'b0);
        lit("after rst", 4'h9, 4'h9, 1'b1, 1'b0, 1'b0);

        // Abutting frames with the consumer always ready
        send_frame(4'h6, 1'b1, 1'b1, 1'b1);
        send_frame(4'h1, 1'b1, 1'b1, 1'b1);
        lit("abut", 4'h1, 4'h8, 1'b1, 1'b0, 1'b0);
        bitcyc(1'b1, 1'b0);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receive-side companion to the universal shift register. It deserializes a framed, strobe-qualified serial bit stream into parallel words. Each frame is one start bit (0), WIDTH data bits and one stop bit (1). Completed words are presented on a valid/ready output port with a single-entry holding buffer. Overrun and framing errors are flagged.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- LSB_FIRST, 1, 1: first data bit received is bit 0; 0: first data bit is bit WIDTH-1
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- ser_i  input  1  serial line, idle high
- ser_en_i  input  1  bit strobe; ser_i is sampled only on cycles with ser_en_i=1
- data_o  output  WIDTH  received word (holding register)
- valid_o  output  1  data_o holds an unconsumed word
- ready_i  input  1  consumer accepts data_o when valid_o=1 and ready_i=1
- busy_o  output  1  frame in progress (state ≠ IDLE)
- overrun_o  output  1  one-cycle pulse: a good frame was dropped because the buffer was full
- frame_err_o  output  1  one-cycle pulse: the stop bit sampled 0

## Operation
- Reset values (rst_i=0, asynchronous): state=IDLE, shift register=0, bit counter=0, data_o=0, valid_o=0, busy_o=0, overrun_o=0, frame_err_o=0.
- **IDLE**
  - On strobe with ser_i=0 (start bit): clear the bit counter, go to DATA.
  - On strobe with ser_i=1: stay in IDLE.
- **DATA**
  - Each strobe shifts ser_i into the shift register and increments the counter.
  - LSB_FIRST=1: shift right with ser_i entering the MSB, so the first bit ends in bit 0.
  - LSB_FIRST=0: shift left with ser_i entering the LSB.
  - When the WIDTH-th bit is sampled (counter = WIDTH-1), go to STOP.
- **STOP**: on strobe, return to IDLE and then:
  - ser_i=1, and valid_o=0 or ready_i=1 this cycle: data_o ← shift register, valid_o ← 1.
  - ser_i=1, valid_o=1 and ready_i=0: word discarded, data_o/valid_o unchanged, overrun_o pulses.
  - ser_i=0: word discarded, frame_err_o pulses, no new load.
  - A stop bit of 0 is never reinterpreted as a new start bit. After a framing error the receiver waits for ser_i=1 in IDLE before accepting a start bit.
- **Handshake**
  - valid_o falls on the cycle after valid_o&ready_i, unless a new word loads that same edge; in that case valid_o stays 1 and data_o takes the new word.
  - data_o is stable while valid_o=1 and ready_i=0.
- Non-strobe cycles: state, counter and shift register hold. Strobes may be back-to-back on every clock.
- Reset mid-frame abandons the partial word. No error is flagged.
- Counter width: $clog2(WIDTH).

## Timing
- Latency: the stop-bit strobe at edge t gives valid_o=1 and the new data_o from t+1 (registered outputs).
- overrun_o and frame_err_o are registered and high for exactly the cycle after the stop-bit strobe.
- busy_o goes high the cycle after the start-bit strobe and low the cycle after the stop-bit strobe.
- Minimum frame length: WIDTH+2 strobes. Frames may abut: the start bit may arrive on the strobe right after the stop bit.
- ready_i has no combinational path to any output.

## Test plan
- **Basic frame.** WIDTH=4, LSB_FIRST=1, strobe every cycle, ser_i = 0,1,0,1,1,1. Expect data_o=4'hD and valid_o=1 one cycle after the stop strobe. ready_i=1 then clears valid_o on the next cycle.
- **MSB-first.** Same bit stream with LSB_FIRST=0. Expect data_o=4'hB.
- **Overrun.** Hold ready_i=0, send 4'hD then 4'h3 back-to-back. Expect data_o stays 4'hD, valid_o=1, overrun_o pulses once after the second stop bit. Repeat with ready_i=1 on the second stop-bit cycle: expect data_o=4'h3, valid_o stays 1, no overrun.
- **Framing error.** Send start, 4'hA, stop=0. Expect frame_err_o pulses for one cycle, valid_o stays 0, state is IDLE. A subsequent good frame 4'h5 is received correctly.
- **Sparse strobes.** Strobe every 3rd cycle with ser_i toggling on non-strobe cycles. Expect only strobed samples to count: 4'hD received, busy_o high across the whole frame.
- **Mid-frame reset.** Assert rst_i low after 2 data bits. Expect all outputs 0 immediately (asynchronous). After release, a full frame 4'h9 is received cleanly.
